// File: rtl/rx_ltssm_sequencer.sv
// rx_ltssm_sequencer
//   Steps the receive-side LTSSM checker through a chain of substates. For
//   each substate it pulses rx_clear and arms a cycle timer. It then waits for
//   rx_finish. On finish it either chains into rx_exitTo or ends the sequence.
//   A timeout retries the same substate a bounded number of times.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   start/start_substate begin a sequence (only honoured in IDLE)
//   follow_exit          chain into rx_exitTo on finish
//   abort                level; return to IDLE, no done pulse
//   timeout_cycles       per-substate timeout in cycles, 0 disables
//   rx_finish/rx_exitTo  completion handshake from the checker
//   substate, rx_clear   drive to the checker
//   busy, done, result   sequence status; result held until next start
//   timed_out            sticky; final substate was abandoned on timeout
//   hop_overflow         sticky; MAX_HOPS was reached
//   retry_cnt            retries used in the current substate
//   timeout_total        (RX_SEQ_STATS_EN only) saturating timeout count
//
// Build option: RX_SEQ_STATS_EN adds the timeout_total statistics counter.

module rx_ltssm_sequencer #(
   parameter int SUBSTATE_W = 5,
   parameter int TIMEOUT_W  = 16,
   parameter int MAX_RETRY  = 3,
   parameter int MAX_HOPS   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [SUBSTATE_W-1:0] start_substate,
   input  logic                  follow_exit,
   input  logic                  abort,
   input  logic [TIMEOUT_W-1:0]  timeout_cycles,
   input  logic                  rx_finish,
   input  logic [SUBSTATE_W-1:0] rx_exitTo,
   output logic [SUBSTATE_W-1:0] substate,
   output logic                  rx_clear,
   output logic                  busy,
   output logic                  done,
   output logic [SUBSTATE_W-1:0] result,
   output logic                  timed_out,
   output logic                  hop_overflow,
`ifdef RX_SEQ_STATS_EN
   output logic [7:0]            timeout_total,
`endif
   output logic [2:0]            retry_cnt
);

   localparam int HOP_W = $clog2(MAX_HOPS + 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [SUBSTATE_W-1:0]   substate_q, substate_d;
   logic [SUBSTATE_W-1:0]   result_q, result_d;
   logic [TIMEOUT_W-1:0]    timer_q, timer_d;
   logic [HOP_W-1:0]        hops_q, hops_d;
   logic [2:0]              retry_q, retry_d;
   logic                    rx_clear_q, rx_clear_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    timed_out_q, timed_out_d;
   logic                    hop_ovf_q, hop_ovf_d;
   logic                    tmo_hit;
   logic                    tmo_evt;
   logic [7:0]              tmo_tot_q, tmo_tot_d;

   // Timer starts at 0 on the first RUN cycle, so the timeout fires on the
   // timeout_cycles-th RUN cycle.
   assign tmo_hit = (timeout_cycles != '0) &&
                    (timer_q == timeout_cycles - TIMEOUT_W'(1));

   always_comb begin
      state_d     = state_q;
      substate_d  = substate_q;
      result_d    = result_q;
      timer_d     = timer_q;
      hops_d      = hops_q;
      retry_d     = retry_q;
      rx_clear_d  = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      timed_out_d = timed_out_q;
      hop_ovf_d   = hop_ovf_q;
      tmo_evt     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_CLEAR;
               substate_d  = start_substate;
               result_d    = '0;
               timed_out_d = 1'b0;
               hop_ovf_d   = 1'b0;
               hops_d      = '0;
               retry_d     = '0;
               rx_clear_d  = 1'b1;
               busy_d      = 1'b1;
            end
         end
         S_CLEAR: begin
            timer_d = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (timer_q != '1) timer_d = timer_q + TIMEOUT_W'(1);
            // Finish has priority over a coincident timeout.
            if (rx_finish) begin
               if (follow_exit && (rx_exitTo != '0)) begin
                  if (hops_q + HOP_W'(1) < HOP_W'(MAX_HOPS)) begin
                     substate_d = rx_exitTo;
                     hops_d     = hops_q + HOP_W'(1);
                     retry_d    = '0;
                     rx_clear_d = 1'b1;
                     state_d    = S_CLEAR;
                  end else begin
                     result_d  = rx_exitTo;
                     hop_ovf_d = 1'b1;
                     done_d    = 1'b1;
                     state_d   = S_DONE;
                  end
               end else begin
                  result_d = rx_exitTo;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end
            end else if (tmo_hit) begin
               tmo_evt = 1'b1;
               if (retry_q < 3'(MAX_RETRY)) begin
                  retry_d    = retry_q + 3'd1;
                  rx_clear_d = 1'b1;
                  state_d    = S_CLEAR;
               end else begin
                  timed_out_d = 1'b1;
                  result_d    = '0;
                  done_d      = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything, including a start in the same cycle.
      if (abort) begin
         state_d     = S_IDLE;
         substate_d  = '0;
         result_d    = result_q;
         timer_d     = timer_q;
         hops_d      = hops_q;
         retry_d     = retry_q;
         rx_clear_d  = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         timed_out_d = timed_out_q;
         hop_ovf_d   = hop_ovf_q;
         tmo_evt     = 1'b0;
      end

      tmo_tot_d = tmo_tot_q;
      if (tmo_evt && (tmo_tot_q != 8'hFF)) tmo_tot_d = tmo_tot_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         substate_q  <= '0;
         result_q    <= '0;
         timer_q     <= '0;
         hops_q      <= '0;
         retry_q     <= '0;
         rx_clear_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timed_out_q <= 1'b0;
         hop_ovf_q   <= 1'b0;
         tmo_tot_q   <= '0;
      end else begin
         state_q     <= state_d;
         substate_q  <= substate_d;
         result_q    <= result_d;
         timer_q     <= timer_d;
         hops_q      <= hops_d;
         retry_q     <= retry_d;
         rx_clear_q  <= rx_clear_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timed_out_q <= timed_out_d;
         hop_ovf_q   <= hop_ovf_d;
`ifdef RX_SEQ_STATS_EN
         tmo_tot_q   <= tmo_tot_d;
`else
         tmo_tot_q   <= '0;
`endif
      end
   end

   assign substate     = substate_q;
   assign rx_clear     = rx_clear_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result       = result_q;
   assign timed_out    = timed_out_q;
   assign hop_overflow = hop_ovf_q;
   assign retry_cnt    = retry_q;
`ifdef RX_SEQ_STATS_EN
   assign timeout_total = tmo_tot_q;
`endif

endmodule
